// File: rtl/codec_cfg_sequencer.sv
// Purpose : schedules codec I2C register writes: 10-word power-up table on i_start, then runtime FIFO writes, with NACK retry.
// Latency : i_start -> o_tx_valid two edges later; success -> next init word after GAP_CYCLES+1 cycles.
// Backpres: holds o_tx_valid/o_tx_data until i_tx_ready; o_req_ready drops when the 4-deep FIFO is full.
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_start                        request the init sequence
//   i_req_valid/i_req_reg/_data    runtime write request (into FIFO), o_req_ready = FIFO not full
//   o_tx_valid/o_tx_data           word offered to the I2C master, {DEV_ADDR, 0, reg, data}
//   i_tx_ready/i_tx_done/i_tx_nack master handshake, completion pulse and NACK qualifier
//   o_init_done, o_busy            init table finished, sequencer not idle
//   o_err, o_err_reg               sticky abandon flag and register of last abandoned word
module codec_cfg_sequencer #(
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         MAX_RETRY  = 2,
    parameter int         GAP_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_req_valid,
    input  logic [6:0]  i_req_reg,
    input  logic [8:0]  i_req_data,
    output logic        o_req_ready,
    output logic        o_tx_valid,
    output logic [23:0] o_tx_data,
    input  logic        i_tx_ready,
    input  logic        i_tx_done,
    input  logic        i_tx_nack,
    output logic        o_init_done,
    output logic        o_busy,
    output logic        o_err,
    output logic [6:0]  o_err_reg
);

    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t         state, state_nxt;
    logic           start_pend;
    logic           init_mode;
    logic           rst_done;
    logic [3:0]     idx;
    logic [RW-1:0]  retry_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [15:0]    fifo_mem [4];
    logic [1:0]     wr_ptr, rd_ptr;
    logic [2:0]     count;

    logic           push, pop, advance;
    logic           take_init, word_ok, word_drop, word_retry, gap_end;
    logic [15:0]    cur_word;

    function automatic logic [8:0] init_data(input logic [3:0] i);
        case (i)
            4'd0, 4'd1: return 9'h097;
            4'd2, 4'd3: return 9'h079;
            4'd4:       return 9'h015;
            4'd7:       return 9'h042;
            4'd8:       return 9'h019;
            4'd9:       return 9'h001;
            default:    return 9'h000;
        endcase
    endfunction

    // Table entry n lives at register n, so the register field is just the index.
    assign cur_word = init_mode ? {3'b000, idx, init_data(idx)} : fifo_mem[rd_ptr];
    assign gap_end  = (gap_cnt == GW'(GAP_CYCLES));
    assign advance  = word_ok | word_drop;
    assign pop      = advance & ~init_mode;
    // rst_done keeps o_req_ready low while reset is held, so every output reads 0 in reset.
    assign o_req_ready = rst_done & (count != 3'd4);
    assign push     = i_req_valid & o_req_ready;

    assign o_tx_valid = (state == S_ISSUE);
    assign o_tx_data  = o_tx_valid ? {DEV_ADDR, 1'b0, cur_word} : 24'h0;
    assign o_busy     = (state != S_IDLE);

    always_comb begin
        state_nxt  = state;
        take_init  = 1'b0;
        word_ok    = 1'b0;
        word_drop  = 1'b0;
        word_retry = 1'b0;
        case (state)
            S_IDLE: begin
                // Init always wins; runtime words only flow once init has completed.
                if (start_pend) begin
                    take_init = 1'b1;
                    state_nxt = S_ISSUE;
                end else if (o_init_done && count != 3'd0) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_tx_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    state_nxt = S_GAP;
                    if (!i_tx_nack)                      word_ok    = 1'b1;
                    else if (retry_cnt < RW'(MAX_RETRY)) word_retry = 1'b1;
                    else                                 word_drop  = 1'b1;
                end
            end
            S_GAP: begin
                // A runtime word (retried or not) goes back through arbitration.
                if (gap_end) state_nxt = (init_mode && idx != 4'd10) ? S_ISSUE : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            start_pend  <= 1'b0;
            init_mode   <= 1'b0;
            rst_done    <= 1'b0;
            idx         <= 4'd0;
            retry_cnt   <= '0;
            gap_cnt     <= '0;
            o_init_done <= 1'b0;
            o_err       <= 1'b0;
            o_err_reg   <= 7'd0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;

            // A start request during init is dropped; during runtime it waits.
            if (take_init)                  start_pend <= 1'b0;
            else if (i_start && !init_mode) start_pend <= 1'b1;

            if (take_init) begin
                init_mode   <= 1'b1;
                idx         <= 4'd0;
                retry_cnt   <= '0;
                o_init_done <= 1'b0;
                o_err       <= 1'b0;
                o_err_reg   <= 7'd0;
            end

            if (word_retry) retry_cnt <= retry_cnt + RW'(1);
            if (advance) begin
                retry_cnt <= '0;
                if (init_mode) idx <= idx + 4'd1;
            end
            if (word_drop) begin
                o_err     <= 1'b1;
                o_err_reg <= cur_word[15:9];
            end

            if (state == S_GAP && !gap_end) gap_cnt <= gap_cnt + GW'(1);
            else                            gap_cnt <= '0;

            if (state == S_GAP && gap_end && init_mode && idx == 4'd10) begin
                init_mode   <= 1'b0;
                o_init_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr] <= {i_req_reg, i_req_data};
    end

endmodule
